// File: rtl/mem_wb_elastic_reg_pkg.sv
// Shared constants for the MEM/WB elastic register.
// Payload bus width helper and the hardwired-zero register index.
package mem_wb_elastic_reg_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int payload_w(
    input int aw,
    input int dw
  );
    return 2 + aw + 2 * dw;
  endfunction

endpackage

// File: rtl/mem_wb_elastic_reg_pipe_skid_buf.sv
// Generic valid/ready buffer: head entry plus optional skid entry.
// in_ready is registered when the skid entry exists.
module pipe_skid_buf #(
  parameter int          PAYLOAD_W = 8,
  parameter int unsigned SKID_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 hv_q, hv_d;
  logic                 sv_q, sv_d;
  logic [PAYLOAD_W-1:0] hd_q, hd_d;
  logic [PAYLOAD_W-1:0] sd_q, sd_d;
  logic                 acc;
  logic                 drn;

  assign drn = hv_q & out_ready;

  if (SKID_EN != 0) begin : g_skid
    assign in_ready = ~sv_q;
  end else begin : g_single
    assign in_ready = ~hv_q | out_ready;
  end

  assign acc = in_valid & in_ready;

  always_comb begin
    hv_d = hv_q;
    sv_d = sv_q;
    hd_d = hd_q;
    sd_d = sd_q;
    if (flush) begin
      hv_d = 1'b0;
      sv_d = 1'b0;
    end else if (sv_q) begin
      if (drn) begin
        hd_d = sd_q;
        sv_d = 1'b0;
      end
    end else if (acc) begin
      if (!hv_q || drn) begin
        hd_d = in_data;
        hv_d = 1'b1;
      end else begin
        sd_d = in_data;
        sv_d = 1'b1;
      end
    end else if (drn) begin
      hv_d = 1'b0;
    end
    if (SKID_EN == 0) begin
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hv_q <= 1'b0;
      sv_q <= 1'b0;
      hd_q <= '0;
      sd_q <= '0;
    end else begin
      hv_q <= hv_d;
      sv_q <= sv_d;
      hd_q <= hd_d;
      sd_q <= sd_d;
    end
  end

  assign out_valid = hv_q;
  assign out_data  = hd_q;

endmodule

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB elastic pipeline register with forwarding tap.
// Packs the payload into a skid buffer and guards writes to x0.
module mem_wb_elastic_reg
  import mem_wb_elastic_reg_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int unsigned SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [ADDR_W-1:0] dst_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PW = payload_w(ADDR_W, DATA_W);

  logic [PW-1:0] in_bus;
  logic [PW-1:0] out_bus;
  logic          dst_nz;

  assign in_bus = {reg_write_in, mem_to_reg_in,
                   dst_in, alu_in, rdata_in};

  pipe_skid_buf #(
    .PAYLOAD_W (PW),
    .SKID_EN   (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bus)
  );

  assign {reg_write_out, mem_to_reg_out,
          dst_out, alu_out, rdata_out} = out_bus;

  assign dst_nz    = (dst_out != ADDR_W'(REG_ZERO));
  assign wb_data   = mem_to_reg_out ? rdata_out : alu_out;
  assign fwd_valid = out_valid & reg_write_out & dst_nz;
  assign wb_we     = fwd_valid & out_ready;
  assign fwd_addr  = dst_out;
  assign fwd_data  = wb_data;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Bench for mem_wb_elastic_reg: skid and single-entry builds side
// by side, checked against a queue model plus directed literals.
module tb_mem_wb_elastic_reg;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] rd;
  } pl_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, ordy;
  logic rw, m2r;
  logic [4:0]  dst;
  logic [31:0] alu, rd;

  logic [1:0] ir, ov, rwo, m2ro, we, fv;
  logic [1:0][4:0]  dsto, fa;
  logic [1:0][31:0] aluo, rdo, wd, fd;

  int n_cmp = 0;
  int n_bad = 0;

  pl_t mq [2][2];
  int  mn [2];
  bit  mz [2];

  always #5 clk = ~clk;

  mem_wb_elastic_reg #(.DATA_W(32), .ADDR_W(5), .SKID_EN(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .reg_write_in(rw), .mem_to_reg_in(m2r),
    .dst_in(dst), .alu_in(alu), .rdata_in(rd),
    .out_valid(ov[0]), .out_ready(ordy),
    .reg_write_out(rwo[0]), .mem_to_reg_out(m2ro[0]),
    .dst_out(dsto[0]), .alu_out(aluo[0]), .rdata_out(rdo[0]),
    .wb_data(wd[0]), .wb_we(we[0]), .fwd_valid(fv[0]),
    .fwd_addr(fa[0]), .fwd_data(fd[0])
  );

  mem_wb_elastic_reg #(.DATA_W(32), .ADDR_W(5), .SKID_EN(0)) u_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .reg_write_in(rw), .mem_to_reg_in(m2r),
    .dst_in(dst), .alu_in(alu), .rdata_in(rd),
    .out_valid(ov[1]), .out_ready(ordy),
    .reg_write_out(rwo[1]), .mem_to_reg_out(m2ro[1]),
    .dst_out(dsto[1]), .alu_out(aluo[1]), .rdata_out(rdo[1]),
    .wb_data(wd[1]), .wb_we(we[1]), .fwd_valid(fv[1]),
    .fwd_addr(fa[1]), .fwd_data(fd[1])
  );

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got=%h want=%h",
               nm, inst, $time, act, exp);
    end
  endtask

  // Model: inst 0 holds up to 2 entries, inst 1 holds 1.
  always begin
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mn[i] = 0;
        mz[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic e_ir, e_ov, e_fv, e_we, acc, drn;
        logic [31:0] e_wd;
        pl_t h;
        h    = mq[i][0];
        e_ov = (mn[i] > 0);
        e_ir = (i == 0) ? (mn[i] < 2) : (mn[i] == 0 || ordy);
        e_wd = h.m2r ? h.rd : h.alu;
        e_fv = e_ov && h.rw && (h.dst != 5'd0);
        e_we = e_fv && ordy;
        chk("in_ready", i, 32'(ir[i]), 32'(e_ir));
        chk("out_valid", i, 32'(ov[i]), 32'(e_ov));
        chk("wb_we", i, 32'(we[i]), 32'(e_we));
        chk("fwd_valid", i, 32'(fv[i]), 32'(e_fv));
        if (e_ov) begin
          chk("reg_write_out", i, 32'(rwo[i]), 32'(h.rw));
          chk("mem_to_reg_out", i, 32'(m2ro[i]), 32'(h.m2r));
          chk("dst_out", i, 32'(dsto[i]), 32'(h.dst));
          chk("alu_out", i, aluo[i], h.alu);
          chk("rdata_out", i, rdo[i], h.rd);
          chk("wb_data", i, wd[i], e_wd);
          chk("fwd_addr", i, 32'(fa[i]), 32'(h.dst));
          chk("fwd_data", i, fd[i], e_wd);
        end else if (mz[i]) begin
          chk("zero_alu", i, aluo[i], 32'd0);
          chk("zero_rdata", i, rdo[i], 32'd0);
          chk("zero_dst", i, 32'(dsto[i]), 32'd0);
          chk("zero_wb_data", i, wd[i], 32'd0);
        end
        acc = in_valid && e_ir;
        drn = e_ov && ordy;
        if (flush) begin
          mn[i] = 0;
        end else begin
          if (drn) begin
            mq[i][0] = mq[i][1];
            mn[i]--;
          end
          if (acc) begin
            mq[i][mn[i]] = '{rw, m2r, dst, alu, rd};
            mn[i]++;
            mz[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input logic v, input logic w,
                      input logic m, input logic [4:0] d,
                      input logic [31:0] a,
                      input logic [31:0] r);
    in_valid = v;
    rw       = w;
    m2r      = m;
    dst      = d;
    alu      = a;
    rd       = r;
  endtask

  task automatic idle();
    cyc();
    setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    ordy  = 1'b1;
    setp(1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAA, 32'h5555);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", i, 32'(ir[i]), 32'd1);
      chk("rst_out_valid", i, 32'(ov[i]), 32'd0);
      chk("rst_wb_we", i, 32'(we[i]), 32'd0);
      chk("rst_wb_data", i, wd[i], 32'd0);
      chk("rst_dst", i, 32'(dsto[i]), 32'd0);
    end

    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k <= 4)
        setp(1'b1, 1'b1, 1'b0, 5'(k), 32'(k * 32'h11), 32'd0);
      else
        setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      if (k >= 2) begin
        chk("stream_wb_data", 0, wd[0], 32'((k - 1) * 32'h11));
        chk("stream_wb_we", 0, 32'(we[0]), 32'd1);
        chk("stream_wb_data", 1, wd[1], 32'((k - 1) * 32'h11));
      end
    end
    idle();
    @(negedge clk);
    chk("bubble_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("bubble_wb_we", 0, 32'(we[0]), 32'd0);

    cyc(); ordy = 1'b0;
    setp(1'b1, 1'b1, 1'b0, 5'd8, 32'hA0, 32'd0);
    cyc();
    setp(1'b1, 1'b1, 1'b0, 5'd9, 32'hB0, 32'd0);
    cyc();
    setp(1'b1, 1'b1, 1'b0, 5'd10, 32'hC0, 32'd0);
    @(negedge clk);
    chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
    chk("bp_in_ready", 1, 32'(ir[1]), 32'd0);
    chk("bp_head_dst", 0, 32'(dsto[0]), 32'd8);
    idle(); ordy = 1'b1;
    @(negedge clk);
    chk("bp_drain1", 0, wd[0], 32'hA0);
    chk("bp_drain1", 1, wd[1], 32'hA0);
    chk("bp_drain1_we", 0, 32'(we[0]), 32'd1);
    idle();
    @(negedge clk);
    chk("bp_drain2", 0, wd[0], 32'hB0);
    chk("bp_single_empty", 1, 32'(ov[1]), 32'd0);
    idle();
    @(negedge clk);
    chk("bp_empty", 0, 32'(ov[0]), 32'd0);

    cyc();
    setp(1'b1, 1'b1, 1'b1, 5'd7, 32'h100, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("load_wb_data", i, wd[i], 32'hDEADBEEF);
      chk("load_fwd_addr", i, 32'(fa[i]), 32'd7);
      chk("load_fwd_valid", i, 32'(fv[i]), 32'd1);
    end

    cyc();
    setp(1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 32'd0);
    idle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("x0_out_valid", i, 32'(ov[i]), 32'd1);
      chk("x0_wb_we", i, 32'(we[i]), 32'd0);
      chk("x0_fwd_valid", i, 32'(fv[i]), 32'd0);
    end

    for (int k = 0; k < 6; k++) begin
      cyc();
      ordy = (k != 3);
      setp(1'b1, 1'b1, 1'(k & 1), 5'(16 + k),
           32'(32'h600 + k), 32'(32'h700 + k));
    end
    cyc(); ordy = 1'b1;
    setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (4) idle();

    cyc(); ordy = 1'b0;
    setp(1'b1, 1'b1, 1'b0, 5'd11, 32'hB1, 32'd0);
    cyc();
    setp(1'b1, 1'b1, 1'b0, 5'd12, 32'hB2, 32'd0);
    cyc(); flush = 1'b1;
    setp(1'b1, 1'b1, 1'b0, 5'd13, 32'hB3, 32'd0);
    cyc(); flush = 1'b0; ordy = 1'b1;
    setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("flush_out_valid", i, 32'(ov[i]), 32'd0);
      chk("flush_in_ready", i, 32'(ir[i]), 32'd1);
      chk("flush_wb_we", i, 32'(we[i]), 32'd0);
    end
    idle();
    @(negedge clk);
    chk("flush_after_we", 0, 32'(we[0]), 32'd0);

    cyc(); flush = 1'b1;
    setp(1'b1, 1'b1, 1'b0, 5'd14, 32'hE1, 32'd0);
    cyc(); flush = 1'b0;
    setp(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("flush_drop_acc", 0, 32'(ov[0]), 32'd0);
    chk("flush_drop_acc", 1, 32'(ov[1]), 32'd0);
    repeat (2) idle();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_elastic_reg.md
Name: mem_wb_elastic_reg

Overview:
Parametrised successor to the fixed MEM/WB pipeline register. It carries the memory-stage payload (write-back control, destination register, ALU result, load data) to write-back through a valid/ready elastic stage with a two-entry skid buffer. It supports pipeline stall, flush and bubble insertion, and provides a forwarding tap for the hazard unit. It sits between the data-memory stage and the register-file write port.

Parameters:
DATA_W, 32, width of ALU result and load data
ADDR_W, 5, width of destination register index
SKID_EN, 1, 1 = two-entry skid buffer (full throughput under backpressure); 0 = single entry, half throughput when stalled

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
in_valid  in  1  MEM stage offers a payload
in_ready  out  1  stage can accept a payload
reg_write_in  in  1  payload: write-back enable
mem_to_reg_in  in  1  payload: 1 = select load data, 0 = ALU result
dst_in  in  ADDR_W  payload: destination register index
alu_in  in  DATA_W  payload: ALU result
rdata_in  in  DATA_W  payload: load data (full word)
out_valid  out  1  head entry valid
out_ready  in  1  write-back accepts head entry
reg_write_out, mem_to_reg_out, dst_out, alu_out, rdata_out  out  as inputs  head-entry payload
wb_data  out  DATA_W  mem_to_reg_out ? rdata_out : alu_out
wb_we  out  1  out_valid & out_ready & reg_write_out & (dst_out != 0)
fwd_valid  out  1  out_valid & reg_write_out & (dst_out != 0)
fwd_addr  out  ADDR_W  dst_out
fwd_data  out  DATA_W  equals wb_data

Behaviour:
- Clock domain is single clk. Reset is synchronous and active-high on rst. All state updates occur on the rising edge of clk.
- Reset: out_valid=0, skid entry invalid, all payload registers zero, so every payload output is 0. in_ready=1 in the cycle after reset. rst takes priority over flush and over any handshake.
- Storage: head entry (drives outputs) plus skid entry when SKID_EN=1. The skid valid bit is a registered flag.
- in_ready is registered: in_ready = !skid_valid when SKID_EN=1. When SKID_EN=0, in_ready = !out_valid | out_ready; this is the one combinational path.
- Accept: in_valid & in_ready. Drain: out_valid & out_ready.
- Head empty, or draining with the skid entry empty: an accept loads the head directly. Latency is 1 cycle from accept to out_valid.
- Head full, not draining, accept: payload goes into the skid entry and in_ready drops the next cycle.
- Drain with the skid entry full: the skid entry moves to the head and the skid entry is cleared. An accept cannot occur in the same cycle because in_ready=0.
- Ordering is strict FIFO and nothing is ever dropped or duplicated, except by flush.
- Payload registers load only on accept or skid move, to save power. Data in invalid entries is don't-care but must not glitch into wb_we.
- flush=1: both valid bits clear at the next edge and any simultaneous accept is discarded. Payload registers hold their values. in_ready=1 on the following cycle.
- in_valid=0 with the head drained leaves a bubble: out_valid=0, so wb_we=0 and fwd_valid=0.
- dst_out==0 never asserts wb_we or fwd_valid (register x0 is hardwired).
- Data width: rdata_in is a full DATA_W word. Sub-word extension is done upstream.
- Throughput: 1 payload per cycle whenever out_ready=1. With SKID_EN=1, 1 per cycle also sustains under a 1-cycle out_ready drop.

Decomposition:
- Shared package/header constants_values.vh gets:
  - `WORD_ZERO, sized by DATA_W
  - `REG_ZERO, 5'd0
  - a payload-width macro: 2+ADDR_W+2*DATA_W
- One sub-module, pipe_skid_buf. It is a generic valid/ready two-entry buffer over a packed payload bus, parameters PAYLOAD_W and SKID_EN.
- mem_wb_elastic_reg packs the fields into that bus and adds the wb_data mux, the wb_we/fwd logic and the x0 guard.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, wb_we=0, all outputs 0, in_ready=1 the cycle after release.
- Streaming: 4 payloads, alu_in=0x11..0x44, dst=1..4, mem_to_reg=0, out_ready=1 -> one cycle later wb_data=0x11,0x22,0x33,0x44 on consecutive cycles, wb_we=1 each cycle.
- Backpressure: out_ready=0 for 3 cycles while offering 3 payloads -> 2 accepted, then in_ready=0. On out_ready=1 they drain in order with no loss. With SKID_EN=0, only 1 is accepted.
- Load select: mem_to_reg_in=1, rdata_in=0xDEADBEEF, alu_in=0x100, dst=7 -> wb_data=0xDEADBEEF, fwd_addr=7, fwd_valid=1.
- x0 guard: reg_write_in=1, dst_in=0 -> out_valid=1, wb_we=0, fwd_valid=0.
- Flush: with both entries full, assert flush together with an in_valid payload -> next cycle out_valid=0, in_ready=1, and no wb_we for any of the 3 payloads.
